// File: rtl/usb_phy_pkg.sv
// Shared definitions for the USB full-speed PHY (receive and transmit sides).
// Contents:
//   CLKS_PER_BIT_DEF    - clk_48mhz cycles per 12 Mb/s bit
//   RESET_SE0_CLKS_DEF  - SE0 clocks (2.5 us) that flag a bus reset
//   line_state_t        - bus line state, encoded as {D-, D+}
//   rx_state_t          - receive FSM state
package usb_phy_pkg;

    localparam int CLKS_PER_BIT_DEF   = 4;
    localparam int RESET_SE0_CLKS_DEF = 120;

    // Zeros that must precede the closing 1 of SYNC, and the run of 1s after
    // which the transmitter inserts a stuff bit.
    localparam int SYNC_MIN_ZEROS = 5;
    localparam int STUFF_RUN      = 6;

    typedef enum logic [1:0] {
        LS_SE0 = 2'd0,
        LS_J   = 2'd1,
        LS_K   = 2'd2,
        LS_SE1 = 2'd3
    } line_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_SYNC  = 2'd1,
        RX_DATA  = 2'd2,
        RX_ERROR = 2'd3
    } rx_state_t;

endpackage

// File: rtl/usb_rx_dpll.sv
// Input synchronizer and bit-recovery DPLL for the full-speed receiver.
// Ports:
//   clk_48mhz, reset  - 48 MHz clock, synchronous active-high reset
//   dp_raw, dn_raw    - asynchronous D+/D- from the pad buffer
//   line_state        - synchronized line state {D-, D+}
//   sample_stb        - high for one clock at the centre of each bit cell
module usb_rx_dpll
    import usb_phy_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic        clk_48mhz,
    input  logic        reset,
    input  logic        dp_raw,
    input  logic        dn_raw,
    output line_state_t line_state,
    output logic        sample_stb
);

    localparam int PW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 2;

    logic [1:0]    dp_sync_q;
    logic [1:0]    dn_sync_q;
    line_state_t   prev_ls_q;
    logic [PW-1:0] phase_q;
    logic [PW-1:0] phase_d;

    assign line_state = line_state_t'({dn_sync_q[1], dp_sync_q[1]});

    // phase_d is the phase of the current clock: 0 on the clock where the
    // line changes, so the strobe lands two clocks into every bit cell and
    // every CLKS_PER_BIT clocks during a run of identical bits.
    always_comb begin
        if (line_state != prev_ls_q) begin
            phase_d = '0;
        end else if (phase_q == PW'(CLKS_PER_BIT - 1)) begin
            phase_d = '0;
        end else begin
            phase_d = phase_q + 1'b1;
        end
    end

    assign sample_stb = (phase_d == PW'(2));

    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            dp_sync_q <= 2'b11;
            dn_sync_q <= 2'b00;
            prev_ls_q <= LS_J;
            phase_q   <= '0;
        end else begin
            dp_sync_q <= {dp_sync_q[0], dp_raw};
            dn_sync_q <= {dn_sync_q[0], dn_raw};
            prev_ls_q <= line_state;
            phase_q   <= phase_d;
        end
    end

endmodule

// File: rtl/usb_fs_rx_phy.sv
// USB full-speed receive PHY: synchronizer/DPLL, NRZI decode, SYNC search,
// bit unstuffing, byte assembly, EOP and bus-reset detection.
// Ports:
//   clk_48mhz, reset  - 48 MHz clock, synchronous active-high reset
//   dp_raw, dn_raw    - asynchronous D+/D- from the pad buffer
//   rx_en             - low while the local transmitter drives the bus
//   line_state        - synchronized line state (0 SE0, 1 J, 2 K, 3 SE1)
//   pkt_start         - one-clock pulse when SYNC completes
//   data, data_valid  - received byte and its one-clock qualifier
//   pkt_end, pkt_err  - one-clock EOP pulse; pkt_err is meaningful only with it
//   usb_reset_det     - high while SE0 has lasted RESET_SE0_CLKS clocks or more
//   rx_state_dbg      - current receive FSM state, for observation only
// Output protocol: there is no back-pressure. pkt_start, data_valid and
// pkt_end are single-clock strobes with no ready; the consumer must take
// data in the clock data_valid is high and pkt_err in the clock pkt_end is.
module usb_fs_rx_phy
    import usb_phy_pkg::*;
#(
    parameter int CLKS_PER_BIT   = CLKS_PER_BIT_DEF,
    parameter int RESET_SE0_CLKS = RESET_SE0_CLKS_DEF
) (
    input  logic       clk_48mhz,
    input  logic       reset,
    input  logic       dp_raw,
    input  logic       dn_raw,
    input  logic       rx_en,
    output logic [1:0] line_state,
    output logic       pkt_start,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       pkt_end,
    output logic       pkt_err,
    output logic       usb_reset_det,
    output rx_state_t  rx_state_dbg
);

    localparam int CW = $clog2(RESET_SE0_CLKS + 1);

    line_state_t ls;
    logic        sample_stb;
    logic        nrzi_bit;

    rx_state_t   state_q;
    line_state_t last_sample_q;
    logic [2:0]  zero_cnt_q;
    logic [2:0]  ones_cnt_q;
    logic [2:0]  bit_cnt_q;
    logic [6:0]  shift_q;
    logic        err_q;
    logic        se0_seen_q;
    logic [7:0]  data_q;
    logic        pkt_start_q;
    logic        data_valid_q;
    logic        pkt_end_q;
    logic        pkt_err_q;
    logic [CW-1:0] se0_cnt_q;
    logic [CW-1:0] se0_cnt_d;
    logic        usb_reset_det_q;

    usb_rx_dpll #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_dpll (
        .clk_48mhz (clk_48mhz),
        .reset     (reset),
        .dp_raw    (dp_raw),
        .dn_raw    (dn_raw),
        .line_state(ls),
        .sample_stb(sample_stb)
    );

    // NRZI: no change since the previous sample is a 1.
    assign nrzi_bit = (ls == last_sample_q);

    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            state_q       <= RX_IDLE;
            last_sample_q <= LS_J;
            zero_cnt_q    <= '0;
            ones_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            err_q         <= 1'b0;
            se0_seen_q    <= 1'b0;
            data_q        <= '0;
            pkt_start_q   <= 1'b0;
            data_valid_q  <= 1'b0;
            pkt_end_q     <= 1'b0;
            pkt_err_q     <= 1'b0;
        end else begin
            pkt_start_q  <= 1'b0;
            data_valid_q <= 1'b0;
            pkt_end_q    <= 1'b0;
            pkt_err_q    <= 1'b0;
            if (sample_stb) begin
                last_sample_q <= ls;
            end
            if (!rx_en) begin
                // Own transmitter owns the bus: drop any packet silently.
                state_q    <= RX_IDLE;
                zero_cnt_q <= '0;
                ones_cnt_q <= '0;
                bit_cnt_q  <= '0;
                err_q      <= 1'b0;
                se0_seen_q <= 1'b0;
            end else if (sample_stb) begin
                case (state_q)
                    RX_IDLE: begin
                        if (ls == LS_K) begin
                            state_q    <= RX_SYNC;
                            zero_cnt_q <= 3'd1;  // the J->K edge is itself a 0
                        end
                    end
                    RX_SYNC: begin
                        if (ls == LS_SE0) begin
                            state_q <= RX_IDLE;
                        end else if (ls == LS_SE1) begin
                            err_q   <= 1'b1;
                            state_q <= RX_ERROR;
                        end else if (nrzi_bit) begin
                            if (zero_cnt_q >= 3'(SYNC_MIN_ZEROS)) begin
                                state_q     <= RX_DATA;
                                pkt_start_q <= 1'b1;
                                ones_cnt_q  <= '0;
                                bit_cnt_q   <= '0;
                                err_q       <= 1'b0;
                                se0_seen_q  <= 1'b0;
                            end else begin
                                state_q <= RX_IDLE;
                            end
                        end else if (zero_cnt_q != 3'd7) begin
                            zero_cnt_q <= zero_cnt_q + 3'd1;
                        end
                    end
                    RX_DATA: begin
                        if (ls == LS_SE0) begin
                            se0_seen_q <= 1'b1;
                        end else if (ls == LS_J && se0_seen_q) begin
                            pkt_end_q  <= 1'b1;
                            pkt_err_q  <= err_q | (bit_cnt_q != 3'd0);
                            state_q    <= RX_IDLE;
                            se0_seen_q <= 1'b0;
                            err_q      <= 1'b0;
                        end else if (ls == LS_SE1 || se0_seen_q) begin
                            // SE1, or SE0 not followed by J, is a broken line.
                            err_q      <= 1'b1;
                            se0_seen_q <= 1'b0;
                            state_q    <= RX_ERROR;
                        end else if (ones_cnt_q == 3'(STUFF_RUN)) begin
                            // Stuff bit position: must be 0 and is dropped.
                            if (nrzi_bit) begin
                                err_q   <= 1'b1;
                                state_q <= RX_ERROR;
                            end else begin
                                ones_cnt_q <= '0;
                            end
                        end else begin
                            ones_cnt_q <= nrzi_bit ? ones_cnt_q + 3'd1 : 3'd0;
                            shift_q    <= {nrzi_bit, shift_q[6:1]};
                            bit_cnt_q  <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                data_q       <= {nrzi_bit, shift_q};
                                data_valid_q <= 1'b1;
                            end
                        end
                    end
                    RX_ERROR: begin
                        if (ls == LS_SE0) begin
                            se0_seen_q <= 1'b1;
                        end else if (ls == LS_J && se0_seen_q) begin
                            pkt_end_q  <= 1'b1;
                            pkt_err_q  <= 1'b1;
                            state_q    <= RX_IDLE;
                            se0_seen_q <= 1'b0;
                            err_q      <= 1'b0;
                        end else begin
                            se0_seen_q <= 1'b0;
                        end
                    end
                    default: state_q <= RX_IDLE;
                endcase
            end
        end
    end

    // Bus reset: consecutive SE0 clocks, saturating, independent of rx_en.
    always_comb begin
        if (ls != LS_SE0) begin
            se0_cnt_d = '0;
        end else if (se0_cnt_q == CW'(RESET_SE0_CLKS)) begin
            se0_cnt_d = se0_cnt_q;
        end else begin
            se0_cnt_d = se0_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            se0_cnt_q       <= '0;
            usb_reset_det_q <= 1'b0;
        end else begin
            se0_cnt_q       <= se0_cnt_d;
            usb_reset_det_q <= (se0_cnt_d == CW'(RESET_SE0_CLKS));
        end
    end

    assign line_state    = ls;
    assign pkt_start     = pkt_start_q;
    assign data          = data_q;
    assign data_valid    = data_valid_q;
    assign pkt_end       = pkt_end_q;
    assign pkt_err       = pkt_err_q;
    assign usb_reset_det = usb_reset_det_q;
    assign rx_state_dbg  = state_q;

endmodule
